// File: rtl/pixel_plot_buffer_if.sv
// Pixel stream, control requests and scan-out bus of the 16x16 plot buffer.
// The driver side uses the master modport and the buffer uses the slave modport.
interface pixel_plot_buffer_if;
  logic        pix_valid;
  logic [3:0]  pix_x;
  logic [3:0]  pix_y;
  logic        pix_ready;
  logic        clear_req;
  logic        scan_start;
  logic        busy;
  logic        scan_valid;
  logic [3:0]  scan_row;
  logic [15:0] scan_data;
  logic        scan_done;
  logic [8:0]  pix_count;

  modport master (
    output pix_valid, pix_x, pix_y, clear_req, scan_start,
    input  pix_ready, busy, scan_valid, scan_row, scan_data, scan_done, pix_count
  );

  modport slave (
    input  pix_valid, pix_x, pix_y, clear_req, scan_start,
    output pix_ready, busy, scan_valid, scan_row, scan_data, scan_done, pix_count
  );
endinterface

// File: rtl/pixel_plot_buffer.sv
// 16x16 one-bit frame buffer: sets plotted pixels, counts distinct lit pixels,
// clears on request and raster-scans rows out with a programmable per-row hold.
module pixel_plot_buffer #(
  parameter int unsigned SCAN_HOLD = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pixel_plot_buffer_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, CLEAR, SCAN} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(SCAN_HOLD - 1);

  state_t      r_state;
  logic [15:0] r_mem [16];
  logic [3:0]  r_row;
  logic [7:0]  r_hold;
  logic        r_busy;
  logic        r_scan_valid;
  logic [3:0]  r_scan_row;
  logic [15:0] r_scan_data;
  logic        r_scan_done;
  logic [8:0]  r_pix_count;
  logic        w_pix_ready;
  logic [3:0]  w_row_next;

  assign w_pix_ready = (r_state == IDLE) && !bus.clear_req && !bus.scan_start;
  assign w_row_next  = r_row + 4'd1;

  assign bus.pix_ready  = w_pix_ready;
  assign bus.busy       = r_busy;
  assign bus.scan_valid = r_scan_valid;
  assign bus.scan_row   = r_scan_row;
  assign bus.scan_data  = r_scan_data;
  assign bus.scan_done  = r_scan_done;
  assign bus.pix_count  = r_pix_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      for (int unsigned i = 0; i < 16; i++) r_mem[i] <= '0;
      r_row        <= '0;
      r_hold       <= '0;
      r_busy       <= 1'b0;
      r_scan_valid <= 1'b0;
      r_scan_row   <= '0;
      r_scan_data  <= '0;
      r_scan_done  <= 1'b0;
      r_pix_count  <= '0;
    end else begin
      r_scan_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.clear_req) begin
            r_state     <= CLEAR;
            r_busy      <= 1'b1;
            r_row       <= '0;
            r_pix_count <= '0;
          end else if (bus.scan_start) begin
            r_state      <= SCAN;
            r_busy       <= 1'b1;
            r_row        <= '0;
            r_hold       <= '0;
            r_scan_valid <= 1'b1;
            r_scan_row   <= '0;
            r_scan_data  <= r_mem[0];
          end else if (bus.pix_valid) begin
            // Upstream repeats its last coordinate, so only a 0->1 bit change counts.
            r_mem[bus.pix_y][bus.pix_x] <= 1'b1;
            if (!r_mem[bus.pix_y][bus.pix_x]) r_pix_count <= r_pix_count + 9'd1;
          end
        end
        CLEAR: begin
          r_mem[r_row] <= '0;
          r_row        <= w_row_next;
          if (r_row == 4'd15) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        SCAN: begin
          if (r_hold == HOLD_LAST) begin
            r_hold <= '0;
            if (r_row == 4'd15) begin
              r_state      <= IDLE;
              r_busy       <= 1'b0;
              r_scan_valid <= 1'b0;
              r_scan_done  <= 1'b1;
            end else begin
              r_row       <= w_row_next;
              r_scan_row  <= w_row_next;
              r_scan_data <= r_mem[w_row_next];
            end
          end else begin
            r_hold <= r_hold + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_plot_buffer.sv
// Directed bench for pixel_plot_buffer: one instance with SCAN_HOLD=1, one with SCAN_HOLD=3.
module tb_pixel_plot_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pixel_plot_buffer_if if1();
  pixel_plot_buffer_if if3();

  pixel_plot_buffer #(.SCAN_HOLD(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  pixel_plot_buffer #(.SCAN_HOLD(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  int n_tests = 0;
  int n_fail  = 0;

  // Selects which instance the scan/clear helpers observe and drive.
  logic        sel = 1'b0;
  logic        m_busy, m_valid, m_done;
  logic [3:0]  m_row;
  logic [15:0] m_data;
  logic [8:0]  m_count;
  assign m_busy  = sel ? if3.busy       : if1.busy;
  assign m_valid = sel ? if3.scan_valid : if1.scan_valid;
  assign m_done  = sel ? if3.scan_done  : if1.scan_done;
  assign m_row   = sel ? if3.scan_row   : if1.scan_row;
  assign m_data  = sel ? if3.scan_data  : if1.scan_data;
  assign m_count = sel ? if3.pix_count  : if1.pix_count;

  logic [15:0] rows [16];
  int          hcnt [16];
  int          vcnt;
  int          done_at;
  int          bcyc;
  logic [15:0] exp_rows [16];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) if3.scan_start = v; else if1.scan_start = v;
  endtask

  task automatic set_clear(input logic v);
    if (sel) if3.clear_req = v; else if1.clear_req = v;
  endtask

  task automatic plot(input logic [3:0] x, input logic [3:0] y);
    @(negedge clk);
    if1.pix_valid = 1'b1; if1.pix_x = x; if1.pix_y = y;
    @(negedge clk);
    if1.pix_valid = 1'b0;
  endtask

  task automatic do_scan();
    @(negedge clk);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    vcnt = 0; done_at = 0;
    for (int r = 0; r < 16; r++) begin rows[r] = 16'hdead; hcnt[r] = 0; end
    for (int i = 1; i <= 200; i++) begin
      if (i > 1) @(negedge clk);
      if (m_valid) begin rows[m_row] = m_data; hcnt[m_row]++; vcnt++; end
      if (m_done) begin done_at = i; break; end
    end
    if (done_at == 0) check_eq("scan_timeout", 32'd0, 32'd1);
  endtask

  // Pulses clear_req; optionally pulses scan_start a few cycles into the clear.
  task automatic do_clear(input bit poke_start);
    @(negedge clk);
    set_clear(1'b1);
    @(negedge clk);
    set_clear(1'b0);
    bcyc = 0;
    for (int i = 0; i < 100; i++) begin
      if (!m_busy) break;
      bcyc++;
      if (poke_start && i == 4) set_start(1'b1);
      if (poke_start && i == 5) set_start(1'b0);
      @(negedge clk);
    end
  endtask

  task automatic check_rows(input string tag);
    for (int r = 0; r < 16; r++) check_eq($sformatf("%s_row%0d", tag, r), rows[r], exp_rows[r]);
  endtask

  initial begin
    if1.pix_valid = 0; if1.pix_x = 0; if1.pix_y = 0; if1.clear_req = 0; if1.scan_start = 0;
    if3.pix_valid = 0; if3.pix_x = 0; if3.pix_y = 0; if3.clear_req = 0; if3.scan_start = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset values
    check_eq("rst_ready", if1.pix_ready, 1);
    check_eq("rst_busy", if1.busy, 0);
    check_eq("rst_valid", if1.scan_valid, 0);
    check_eq("rst_row", if1.scan_row, 0);
    check_eq("rst_data", if1.scan_data, 0);
    check_eq("rst_done", if1.scan_done, 0);
    check_eq("rst_count", if1.pix_count, 0);

    // Single pixel (3,5)
    plot(4'd3, 4'd5);
    check_eq("single_count", if1.pix_count, 1);
    do_scan();
    for (int r = 0; r < 16; r++) exp_rows[r] = 16'h0;
    exp_rows[5] = 16'h0008;
    check_rows("single");
    check_eq("single_done_at", done_at, 17);
    check_eq("single_vcnt", vcnt, 16);
    @(negedge clk);
    check_eq("single_busy_after", if1.busy, 0);
    check_eq("single_row_kept", if1.scan_row, 15);

    // Duplicate stream (7,7) x5
    do_clear(1'b0);
    check_eq("clr1_busy_cycles", bcyc, 16);
    @(negedge clk);
    if1.pix_valid = 1'b1; if1.pix_x = 4'd7; if1.pix_y = 4'd7;
    repeat (5) @(negedge clk);
    if1.pix_valid = 1'b0;
    check_eq("dup_count", if1.pix_count, 1);
    do_scan();
    for (int r = 0; r < 16; r++) exp_rows[r] = 16'h0;
    exp_rows[7] = 16'h0080;
    check_rows("dup");

    // Diagonal plus (15,0), one pixel per cycle
    do_clear(1'b0);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      if1.pix_valid = 1'b1; if1.pix_x = 4'(i); if1.pix_y = 4'(i);
      @(negedge clk);
    end
    if1.pix_x = 4'd15; if1.pix_y = 4'd0;
    @(negedge clk);
    if1.pix_valid = 1'b0;
    check_eq("diag_count", if1.pix_count, 17);
    do_scan();
    for (int r = 0; r < 16; r++) exp_rows[r] = 16'(1 << r);
    exp_rows[0] = 16'h8001;
    check_rows("diag");

    // Ten pixels then clear, with a scan_start pulse ignored mid-clear
    do_clear(1'b0);
    for (int i = 0; i < 10; i++) plot(4'(i), 4'd2);
    check_eq("ten_count", if1.pix_count, 10);
    do_clear(1'b1);
    check_eq("clr_busy_cycles", bcyc, 16);
    check_eq("clr_count", if1.pix_count, 0);
    repeat (3) begin
      check_eq("clr_no_scan_busy", if1.busy, 0);
      check_eq("clr_no_scan_valid", if1.scan_valid, 0);
      @(negedge clk);
    end
    do_scan();
    for (int r = 0; r < 16; r++) exp_rows[r] = 16'h0;
    check_rows("clr");

    // Reset mid-scan
    plot(4'd1, 4'd1);
    check_eq("pre_rst_count", if1.pix_count, 1);
    @(negedge clk);
    if1.scan_start = 1'b1;
    @(negedge clk);
    if1.scan_start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("midscan_valid", if1.scan_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mrst_valid", if1.scan_valid, 0);
    check_eq("mrst_busy", if1.busy, 0);
    check_eq("mrst_count", if1.pix_count, 0);
    check_eq("mrst_row", if1.scan_row, 0);
    rst_n = 1'b1;
    @(negedge clk);
    do_scan();
    check_rows("mrst");
    check_eq("mrst_vcnt", vcnt, 16);

    // SCAN_HOLD=3: simultaneous pixel, clear and scan requests
    sel = 1'b1;
    @(negedge clk);
    if3.pix_valid = 1'b1; if3.pix_x = 4'd0; if3.pix_y = 4'd15;
    if3.clear_req = 1'b1; if3.scan_start = 1'b1;
    #1 check_eq("h3_ready_low", if3.pix_ready, 0);
    @(negedge clk);
    if3.pix_valid = 1'b0; if3.clear_req = 1'b0; if3.scan_start = 1'b0;
    check_eq("h3_busy", if3.busy, 1);
    check_eq("h3_no_scan", if3.scan_valid, 0);
    bcyc = 0;
    for (int i = 0; i < 100; i++) begin
      if (!if3.busy) break;
      bcyc++;
      check_eq("h3_clear_no_valid", if3.scan_valid, 0);
      @(negedge clk);
    end
    check_eq("h3_busy_cycles", bcyc, 16);
    check_eq("h3_count", if3.pix_count, 0);
    do_scan();
    check_eq("h3_vcnt", vcnt, 48);
    check_eq("h3_done_at", done_at, 49);
    for (int r = 0; r < 16; r++) check_eq($sformatf("h3_hold%0d", r), hcnt[r], 3);
    check_rows("h3");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pixel_plot_buffer.md
# pixel_plot_buffer

A 16×16 one-bit frame buffer that sits directly downstream of the chip's line-drawing stage. It accepts the stream of packed 4-bit pixel coordinates that stage emits and sets the addressed bits. It counts distinct lit pixels, clears the bitmap on request, and raster-scans it out one 16-bit row at a time for the output pins or a display driver.

## Interface
- SCAN_HOLD, default 1: cycles each scanned row stays on the output. Legal range 1–255.
- clk  input  1  clock; all state is updated on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- pix_valid  input  1  a pixel coordinate is present on pix_x/pix_y.
- pix_x  input  4  column of the pixel, 0–15.
- pix_y  input  4  row of the pixel, 0–15.
- pix_ready  output  1  combinational; a pixel is accepted on any edge where pix_valid && pix_ready.
- clear_req  input  1  request to clear the whole bitmap; sampled only in IDLE.
- scan_start  input  1  request to start a raster scan; sampled only in IDLE.
- busy  output  1  registered; 1 in the CLEAR and SCAN states.
- scan_valid  output  1  registered; scan_row and scan_data are valid.
- scan_row  output  4  registered; index of the row being output.
- scan_data  output  16  registered; bitmap row, bit i = column x=i.
- scan_done  output  1  registered; one-cycle pulse after the last row of a scan.
- pix_count  output  9  registered; number of distinct set bits, 0–256.

## Operation
- Storage: 16 rows × 16 bits held in flops, all asynchronously reset to 0.
- FSM states: IDLE, CLEAR, SCAN. Reset state is IDLE.
- pix_ready = (state == IDLE) && !clear_req && !scan_start.
- Pixel write, on an accepted pixel: set bit mem[pix_y][pix_x].
  - If that bit was 0, increment pix_count.
  - If it was already 1, leave pix_count unchanged. This matters because the upstream stage holds its last coordinate, so duplicate pixels are normal.
- IDLE transitions:
  - clear_req=1 → CLEAR. clear_req has priority over scan_start.
  - Otherwise scan_start=1 → SCAN.
  - Requests that arrive outside IDLE are ignored. They are not queued.
- CLEAR:
  - pix_count is set to 0 on the entry edge.
  - One row is zeroed per cycle, row counter 0..15.
  - After row 15 the FSM returns to IDLE, after 16 cycles in CLEAR.
- SCAN:
  - Row counter r runs 0..15. Each row is presented for SCAN_HOLD cycles with scan_valid=1, scan_row=r, scan_data=mem[r].
  - The hold counter is 8 bits.
  - After the final hold cycle of row 15: scan_valid=0, scan_done=1 for one cycle, FSM returns to IDLE.
  - The bitmap is never modified during SCAN, because pix_ready=0.
- scan_data and scan_row keep their last values when scan_valid=0. They return to 0 only on reset.
- pix_count never exceeds 256 (9 bits is enough), so no saturation logic is needed.

## Timing
- Reset values: pix_ready=1 (IDLE, with inputs low), busy=0, scan_valid=0, scan_row=0, scan_data=0, scan_done=0, pix_count=0, bitmap all zero.
- Reset mid-operation immediately returns the block to IDLE with all of the above values. Any scan or clear in progress is abandoned.
- Pixel write:
  - Bit is visible in mem on edge k+1 after acceptance at edge k.
  - pix_count updates on the same edge.
  - One pixel per cycle is sustained in IDLE.
- scan_start sampled at edge k:
  - busy=1 and scan_valid=1 with row 0 from edge k+1.
  - Row r occupies cycles k+1+r·SCAN_HOLD through k+(r+1)·SCAN_HOLD.
  - scan_done is high for the cycle after edge k+1+16·SCAN_HOLD; busy falls on that same edge.
- clear_req sampled at edge k: busy=1 for 16 cycles, returning to IDLE at edge k+17.
- Simultaneous pix_valid, clear_req and scan_start in IDLE: the pixel is not accepted (pix_ready=0), CLEAR is entered, and scan_start is dropped.

## Test plan
- Reset: hold rst_n=0 mid-scan → next cycle scan_valid=0, busy=0, pix_count=0. A following scan (SCAN_HOLD=1) outputs scan_data=0 for all 16 rows.
- Single pixel (x=3, y=5) → pix_count=1. Scan gives row 5 data=16'h0008 and all other rows 0. scan_done fires 17 cycles after scan_start.
- Stream (7,7) for 5 consecutive cycles → pix_count=1 and row 7 data=16'h0080.
- Diagonal (i,i) for i=0..15, then (15,0) → pix_count=17. Row i data=1<<i, except row 0 = 16'h8001.
- Set 10 pixels, assert clear_req → busy high for exactly 16 cycles and pix_count=0. A following scan returns all zeros. scan_start pulsed during CLEAR is ignored.
- SCAN_HOLD=3, pixel (0,15): assert clear_req, scan_start and pix_valid together → pixel rejected and CLEAR entered. A later scan holds each row for 3 cycles, with 48 scan_valid cycles in total.
